// File: rtl/snake_sequencer.sv
// ---------------------------------------------------------------------------
// snake_sequencer
// Game sequencer for a snake game: drives the IDLE/RUN/PAUSE/DEAD state
// machine, generates the move_tick pulse at a level-dependent rate, commits
// direction changes on move ticks, and tracks the speed level.
//
// Optional feature: define SNAKE_PAUSE_EN to enable RUN<->PAUSE toggling via
// key_pause. Without it key_pause is ignored and PAUSE (11) is unreachable.
//
// Parameters:
//   TICK_DIV   clock cycles per move at level 0
//   TICK_STEP  cycles removed from the move period per level
//   DEAD_HOLD  cycles spent in DEAD before returning to IDLE
//
// Ports:
//   clk          system clock, posedge
//   rst          synchronous active-high reset
//   key_start    start pulse (IDLE -> RUN)
//   key_pause    pause/resume toggle pulse
//   dir_valid    direction request strobe
//   dir_req      requested direction (00 up, 01 down, 10 left, 11 right)
//   dead_wall    head hit wall
//   dead_it      head hit own body
//   food_eaten   food pulse
//   move_tick    one-cycle pulse commanding one snake step
//   dir_cur      committed direction used by the current step
//   game_status  00 IDLE, 01 RUN, 10 DEAD, 11 PAUSE
//   level        speed level 0..7
// ---------------------------------------------------------------------------
module snake_sequencer #(
    parameter int unsigned TICK_DIV  = 20,
    parameter int unsigned TICK_STEP = 2,
    parameter int unsigned DEAD_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    input  logic       dead_wall,
    input  logic       dead_it,
    input  logic       food_eaten,
    output logic       move_tick,
    output logic [1:0] dir_cur,
    output logic [1:0] game_status,
    output logic [2:0] level
);

    localparam int unsigned MIN_PERIOD = 4;
    localparam int unsigned MAX_PERIOD = (TICK_DIV > MIN_PERIOD) ? TICK_DIV : MIN_PERIOD;
    localparam int unsigned CNT_W      = $clog2(MAX_PERIOD + 1);
    localparam int unsigned HOLD_W     = (DEAD_HOLD > 2) ? $clog2(DEAD_HOLD) : 1;
    localparam int unsigned HOLD_LAST  = (DEAD_HOLD > 0) ? DEAD_HOLD - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DEAD  = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    tick_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [1:0]          pending;

    logic [CNT_W-1:0]    period_m1_c;
    logic                death_c;
    logic                dir_ok_c;
    logic                pause_c;

    // Last count value of the move period: TICK_DIV - level*TICK_STEP, floored.
    always_comb begin
        int unsigned dec;
        dec = 32'(level) * TICK_STEP;
        if (TICK_DIV >= dec + MIN_PERIOD) begin
            period_m1_c = CNT_W'(TICK_DIV - dec - 1);
        end else begin
            period_m1_c = CNT_W'(MIN_PERIOD - 1);
        end
    end

    assign death_c  = dead_wall | dead_it;

    // A reversal keeps the axis (bit1) but flips the sense (bit0).
    assign dir_ok_c = !((dir_req[1] == dir_cur[1]) && (dir_req[0] != dir_cur[0]));

`ifdef SNAKE_PAUSE_EN
    assign pause_c = key_pause;
`else
    logic unused_key_pause;
    assign unused_key_pause = key_pause;
    assign pause_c = 1'b0;
`endif

    assign game_status = state;

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
            pending   <= 2'b11;
            dir_cur   <= 2'b11;
            level     <= '0;
            move_tick <= 1'b0;
        end else begin
            move_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_start) begin
                        state    <= ST_RUN;
                        tick_cnt <= '0;
                        level    <= '0;
                        dir_cur  <= 2'b11;
                        pending  <= 2'b11;
                    end
                end
                ST_RUN: begin
                    if (death_c) begin
                        state    <= ST_DEAD;
                        hold_cnt <= '0;
                    end else if (pause_c) begin
                        state <= ST_PAUSE;
                    end else begin
                        // >= keeps the tick timely if a level-up shrank the period.
                        if (tick_cnt >= period_m1_c) begin
                            move_tick <= 1'b1;
                            tick_cnt  <= '0;
                            dir_cur   <= pending;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                        if (dir_valid && dir_ok_c) begin
                            pending <= dir_req;
                        end
                        if (food_eaten && (level != 3'd7)) begin
                            level <= level + 3'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (death_c) begin
                        state    <= ST_DEAD;
                        hold_cnt <= '0;
                    end else if (pause_c) begin
                        state <= ST_RUN;
                    end
                end
                ST_DEAD: begin
                    if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_sequencer.sv
// ---------------------------------------------------------------------------
// tb_snake_sequencer
// Self-checking bench for snake_sequencer: directed scenarios plus a
// randomized run, all compared against a behavioural game model every cycle.
// Honours SNAKE_PAUSE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_snake_sequencer;

    localparam int TICK_DIV  = 20;
    localparam int TICK_STEP = 2;
    localparam int DEAD_HOLD = 8;
`ifdef SNAKE_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DEAD  = 2;
    localparam int S_PAUSE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start = 1'b0;
    logic       key_pause = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_req = 2'b00;
    logic       dead_wall = 1'b0;
    logic       dead_it = 1'b0;
    logic       food_eaten = 1'b0;
    logic       move_tick;
    logic [1:0] dir_cur;
    logic [1:0] game_status;
    logic [2:0] level;

    snake_sequencer #(
        .TICK_DIV (TICK_DIV),
        .TICK_STEP(TICK_STEP),
        .DEAD_HOLD(DEAD_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_start  (key_start),
        .key_pause  (key_pause),
        .dir_valid  (dir_valid),
        .dir_req    (dir_req),
        .dead_wall  (dead_wall),
        .dead_it    (dead_it),
        .food_eaten (food_eaten),
        .move_tick  (move_tick),
        .dir_cur    (dir_cur),
        .game_status(game_status),
        .level      (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Game model: status, cycles elapsed in the current move, level, directions.
    int m_status = S_IDLE;
    int m_phase  = 0;
    int m_level  = 0;
    int m_dir    = 3;
    int m_pend   = 3;
    int m_hold   = 0;
    int m_tick   = 0;

    int cyc      = 0;
    int dut_last = 0;
    int dut_gap  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    endtask

    function automatic int move_period(input int lvl);
        int p;
        p = TICK_DIV - lvl * TICK_STEP;
        return (p < 4) ? 4 : p;
    endfunction

    function automatic bit tick_due();
        return (m_status == S_RUN) && (m_phase + 1 >= move_period(m_level));
    endfunction

    task automatic model_update(input bit r, input bit ks, input bit kp, input bit dv,
                                input int dr, input bit fe, input bit dd);
        int old_dir;
        m_tick = 0;
        if (r) begin
            m_status = S_IDLE; m_phase = 0; m_level = 0;
            m_dir = 3; m_pend = 3; m_hold = 0;
            return;
        end
        case (m_status)
            S_IDLE: if (ks) begin
                m_status = S_RUN; m_phase = 0; m_level = 0; m_dir = 3; m_pend = 3;
            end
            S_RUN: begin
                if (dd) begin
                    m_status = S_DEAD; m_hold = 0;
                end else if (PAUSE_EN && kp) begin
                    m_status = S_PAUSE;
                end else begin
                    old_dir = m_dir;
                    if (m_phase + 1 >= move_period(m_level)) begin
                        m_tick = 1; m_phase = 0; m_dir = m_pend;
                    end else begin
                        m_phase++;
                    end
                    if (dv && dr != (old_dir ^ 1)) m_pend = dr;
                    if (fe && m_level < 7) m_level++;
                end
            end
            S_PAUSE: begin
                if (dd) begin
                    m_status = S_DEAD; m_hold = 0;
                end else if (kp) begin
                    m_status = S_RUN;
                end
            end
            default: begin
                if (m_hold == DEAD_HOLD - 1) m_status = S_IDLE;
                else m_hold++;
            end
        endcase
    endtask

    // One clock: inputs are sampled at the edge, pulses cleared, then compare.
    task automatic step();
        bit r, ks, kp, dv, fe, dd;
        int dr;
        r = rst; ks = key_start; kp = key_pause; dv = dir_valid;
        fe = food_eaten; dd = dead_wall | dead_it; dr = int'(dir_req);
        @(posedge clk);
        #1;
        rst = 1'b0; key_start = 1'b0; key_pause = 1'b0; dir_valid = 1'b0;
        food_eaten = 1'b0; dead_wall = 1'b0; dead_it = 1'b0;
        cyc++;
        model_update(r, ks, kp, dv, dr, fe, dd);
        if (move_tick) begin
            dut_gap  = cyc - dut_last;
            dut_last = cyc;
        end
        check("move_tick",   int'(move_tick),   m_tick);
        check("game_status", int'(game_status), m_status);
        check("dir_cur",     int'(dir_cur),     m_dir);
        check("level",       int'(level),       m_level);
    endtask

    task automatic wait_dut_tick(input string tag);
        for (int i = 0; i < 100; i++) begin
            step();
            if (move_tick) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n;

        // Reset state
        rst = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("rst_status", int'(game_status), 0);
        check("rst_tick",   int'(move_tick),   0);
        check("rst_dir",    int'(dir_cur),     3);
        check("rst_level",  int'(level),       0);

        // Start then idle: three ticks 20 cycles apart, direction right
        key_start = 1'b1;
        step();
        n = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (move_tick) n++;
        end
        check("start_tick_count", n, 3);
        check("start_tick_gap",   dut_gap, 20);
        check("start_dir",        int'(dir_cur), 3);

        // Reversal ignored; accepted request commits only at next tick
        dir_valid = 1'b1; dir_req = 2'b10;
        step();
        dir_valid = 1'b1; dir_req = 2'b00;
        step();
        check("dir_before_tick", int'(dir_cur), 3);
        wait_dut_tick("dir_tick");
        check("dir_at_tick", int'(dir_cur), 0);

        // Level 3 -> 14-cycle spacing, level 7 -> 6-cycle spacing
        for (int i = 0; i < 3; i++) begin
            food_eaten = 1'b1;
            step();
        end
        check("level3", int'(level), 3);
        wait_dut_tick("lvl3_a");
        wait_dut_tick("lvl3_b");
        check("lvl3_gap", dut_gap, 14);
        for (int i = 0; i < 7; i++) begin
            food_eaten = 1'b1;
            step();
        end
        check("level7", int'(level), 7);
        wait_dut_tick("lvl7_a");
        wait_dut_tick("lvl7_b");
        check("lvl7_gap", dut_gap, 6);

        // Death on a due tick: no tick, DEAD for exactly 8 cycles, start ignored
        for (int i = 0; i < 50 && !tick_due(); i++) step();
        check("due_reached", int'(tick_due()), 1);
        dead_it = 1'b1;
        step();
        check("death_no_tick", int'(move_tick), 0);
        check("death_status",  int'(game_status), 2);
        for (int i = 0; i < 7; i++) begin
            key_start = 1'b1;
            step();
            check("dead_hold", int'(game_status), 2);
        end
        key_start = 1'b1;
        step();
        check("dead_to_idle", int'(game_status), 0);
        step();
        check("dead_start_ignored", int'(game_status), 0);

        // Pause at count 10, resume after 50 cycles
        key_start = 1'b1;
        step();
        for (int i = 0; i < 40 && m_phase != 10; i++) step();
        check("pause_count_reached", m_phase, 10);
        key_pause = 1'b1;
        step();
        check("pause_status", int'(game_status), PAUSE_EN ? 3 : 1);
        for (int i = 0; i < 50; i++) step();
        check("pause_hold_status", int'(game_status), PAUSE_EN ? 3 : 1);
        key_pause = 1'b1;
        step();
        check("resume_status", int'(game_status), 1);
        if (PAUSE_EN) begin
            n = 0;
            for (int i = 0; i < 40 && !move_tick; i++) begin
                step();
                n++;
            end
            check("resume_tick_delay", n, 10);
        end

        // Reset mid-RUN at level 5 with a non-default direction
        rst = 1'b1;
        step();
        key_start = 1'b1;
        step();
        dir_valid = 1'b1; dir_req = 2'b01;
        step();
        wait_dut_tick("pre_rst_tick");
        for (int i = 0; i < 5; i++) begin
            food_eaten = 1'b1;
            step();
        end
        check("pre_rst_level", int'(level), 5);
        check("pre_rst_dir",   int'(dir_cur), 1);
        rst = 1'b1; food_eaten = 1'b1; dir_valid = 1'b1; dir_req = 2'b00;
        step();
        check("mid_rst_status", int'(game_status), 0);
        check("mid_rst_tick",   int'(move_tick),   0);
        check("mid_rst_dir",    int'(dir_cur),     3);
        check("mid_rst_level",  int'(level),       0);

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            key_start  = ($urandom_range(0, 19) == 0);
            key_pause  = ($urandom_range(0, 39) == 0);
            dir_valid  = ($urandom_range(0, 5) == 0);
            dir_req    = 2'($urandom_range(0, 3));
            food_eaten = ($urandom_range(0, 14) == 0);
            dead_wall  = ($urandom_range(0, 149) == 0);
            dead_it    = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
